// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and hex-to-segment table for the seven-segment scan driver
package seg7_pkg;

    // {dp,g,f,e,d,c,b,a}, active-low at the pins
    typedef logic [7:0] seg_t;

    localparam seg_t SEG_OFF = 8'hFF;

    // Active-high gfedcba patterns, entry n is hex digit n (0 is the last element listed)
    localparam logic [15:0][6:0] HEX7 = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - load handshake bundle (valid/ready plus digit and dp payload)
interface seg7_scan_driver_if #(
    parameter int N_DIGITS = 4
) ();

    logic                    ld_valid;
    logic                    ld_ready;
    logic [4*N_DIGITS-1:0]   digits_in;
    logic [N_DIGITS-1:0]     dp_in;

    modport master (
        output ld_valid,
        output digits_in,
        output dp_in,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  digits_in,
        input  dp_in,
        output ld_ready
    );

endinterface

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational nibble + dp + blank to active-low segment pattern
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output seg_t       seg
);

    // A blanked digit keeps its decimal point so a "0.5"-style display still reads correctly
    always_comb begin
        seg = SEG_OFF;
        if (blank) begin
            seg = {~dp, 7'h7F};
        end else begin
            seg = ~{dp, HEX7[nibble]};
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - tear-free N-digit common-anode scan driver (option: LEADING_ZERO_BLANK_EN)
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int CLK_HZ     = 50_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int BLANK_CYC  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_scan_driver_if.slave    ld,
    output seg_t                 seg,
    output logic [N_DIGITS-1:0]  an,
    output logic                 frame_tick
);

    localparam int DIV_RAW = CLK_HZ / (REFRESH_HZ * N_DIGITS);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic                    pending;
    logic [4*N_DIGITS-1:0]   pend_digits;
    logic [N_DIGITS-1:0]     pend_dp;
    logic [4*N_DIGITS-1:0]   disp_digits;
    logic [N_DIGITS-1:0]     disp_dp;
    logic [N_DIGITS-1:0]     blank;

    logic                    slot_end;
    logic                    wrap;
    logic                    accept;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    seg_t                    dec_seg;

    assign slot_end    = (presc == PRESC_LAST);
    assign wrap        = slot_end && (idx == IDX_LAST);
    // Ready is simply "nothing waiting for the next frame"; it drops after a capture and
    // comes back the cycle after the wrap that commits it
    assign ld.ld_ready = ~pending;
    assign accept      = ld.ld_valid && ld.ld_ready;

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;

    // Walk down from the most significant digit; blank while every nibble so far is zero,
    // never touching digit 0 so a zero value still shows a single "0"
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (disp_digits[4*i +: 4] == 4'h0);
            blank[i] = zero_run;
        end
    end
`else
    assign blank = '0;
`endif

    // Select the committed nibble, dp and blank flag of the digit currently being scanned
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib   = disp_digits[4*i +: 4];
                cur_dp    = disp_dp[i];
                cur_blank = blank[i];
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .blank  (cur_blank),
        .seg    (dec_seg)
    );

    // Scan timing plus the pending/display double buffer; display only changes on a frame wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc       <= '0;
            idx         <= '0;
            pending     <= 1'b0;
            pend_digits <= '0;
            pend_dp     <= '0;
            disp_digits <= '0;
            disp_dp     <= '0;
        end else begin
            if (slot_end) begin
                presc <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end

            // Commit and accept are exclusive: accept needs pending clear, commit needs it set
            if (wrap && pending) begin
                disp_digits <= pend_digits;
                disp_dp     <= pend_dp;
                pending     <= 1'b0;
            end

            if (accept) begin
                pend_digits <= ld.digits_in;
                pend_dp     <= ld.dp_in;
                pending     <= 1'b1;
            end
        end
    end

    // Pin registers: anodes stay off for the first BLANK_CYC clocks of each slot to stop ghosting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= SEG_OFF;
            an         <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap;
            seg        <= dec_seg;
            if (presc >= BLANK_END) begin
                an <= ~(N_DIGITS'(1) << idx);
            end else begin
                an <= '1;
            end
        end
    end

endmodule
